// File: rtl/axis_feature_assembler_pkg.sv
// axis_feature_assembler_pkg: shared state encoding and feature-vector width rule
package axis_feature_assembler_pkg;
  typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} state_t;
  function automatic int feature_width(input int data_width, input int packets_num);
    return data_width * packets_num;
  endfunction
endpackage

// File: rtl/axis_feature_assembler_sat_counter.sv
// sat_counter: increments on inc and sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    count <= rst ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/axis_feature_assembler.sv
// axis_feature_assembler: packs a fixed-length AXIS frame into one wide feature vector
module axis_feature_assembler
  import axis_feature_assembler_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int PACKETS_NUM   = 13,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [DATA_WIDTH-1:0]                               s_axis_tdata,
  input  logic                                                s_axis_tvalid,
  output logic                                                s_axis_tready,
  input  logic                                                s_axis_tlast,
  output logic [feature_width(DATA_WIDTH, PACKETS_NUM)-1:0]   m_feat_data,
  output logic                                                m_feat_valid,
  input  logic                                                m_feat_ready,
  output logic                                                frame_err,
  output logic [ERR_CNT_WIDTH-1:0]                            err_count,
  output logic [$clog2(PACKETS_NUM)-1:0]                      word_idx
);
  localparam int IW = $clog2(PACKETS_NUM);
  state_t state, next_state;
  logic collect_beat, last_slot, err_set, release_hold;
  assign last_slot = word_idx == IW'(PACKETS_NUM - 1);
  always_comb begin
    s_axis_tready = state != HOLD;
    m_feat_valid  = state == HOLD;
    collect_beat  = state == COLLECT && s_axis_tvalid;
    release_hold  = state == HOLD && m_feat_ready;
    err_set       = collect_beat && (s_axis_tlast != last_slot);
    next_state    = state;
    if (collect_beat && last_slot)
      next_state = s_axis_tlast ? HOLD : DRAIN;
    else if (release_hold)
      next_state = COLLECT;
    else if (state == DRAIN && s_axis_tvalid && s_axis_tlast)
      next_state = COLLECT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      word_idx    <= '0;
      frame_err   <= 1'b0;
      m_feat_data <= '0;
    end else begin
      state     <= next_state;
      frame_err <= err_set;
      if (collect_beat) begin
        m_feat_data[word_idx*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata;
        word_idx <= (s_axis_tlast || last_slot) ? '0 : word_idx + 1'b1;
      end else if (release_hold) begin
        word_idx <= '0;
      end
    end
  end
  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_set),
    .count(err_count)
  );
endmodule

// File: tb/tb_axis_feature_assembler.sv
// tb_axis_feature_assembler: frame-level reference model driving a default and a 2-bit-counter instance
module tb_axis_feature_assembler;
  localparam int DW = 64;
  localparam int P  = 13;
  localparam int FW = DW * P;
  logic clk = 1'b0;
  logic rst, tvalid, tlast, mready;
  logic [DW-1:0] tdata;
  logic a_tready, a_valid, a_ferr, b_tready, b_valid, b_ferr;
  logic [FW-1:0] a_data, b_data;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  logic [3:0] a_idx, b_idx;
  logic [FW-1:0] exp_vec;
  int e8, e2, total, bad;
  always #5 clk = ~clk;
  axis_feature_assembler #(.DATA_WIDTH(DW), .PACKETS_NUM(P), .ERR_CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(a_tready),
    .s_axis_tlast(tlast), .m_feat_data(a_data), .m_feat_valid(a_valid), .m_feat_ready(mready),
    .frame_err(a_ferr), .err_count(a_cnt), .word_idx(a_idx));
  axis_feature_assembler #(.DATA_WIDTH(DW), .PACKETS_NUM(P), .ERR_CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(b_tready),
    .s_axis_tlast(tlast), .m_feat_data(b_data), .m_feat_valid(b_valid), .m_feat_ready(mready),
    .frame_err(b_ferr), .err_count(b_cnt), .word_idx(b_idx));
  task automatic chk(input string tag, input logic [FW-1:0] o, input logic [FW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic chk_counts();
    chk("err_count8", FW'(a_cnt), FW'(e8));
    chk("err_count2", FW'(b_cnt), FW'(e2));
  endtask
  task automatic send_frame(input int n, input bit seq);
    int eb;
    logic [DW-1:0] d;
    eb = (n < P) ? n - 1 : (n > P) ? P - 1 : -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) chk("frame_err", FW'(a_ferr), FW'(i - 1 == eb));
      chk("tready", FW'(a_tready), FW'(1));
      chk("valid_low", FW'(a_valid), FW'(0));
      chk("word_idx", FW'(a_idx), FW'((i < P) ? i : 0));
      d = seq ? DW'(i + 1) : {$urandom(), $urandom()};
      tdata  = d;
      tvalid = 1'b1;
      tlast  = (i == n - 1);
      mready = 1'($urandom_range(0, 1));
      if (i < P) exp_vec[i*DW +: DW] = d;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    mready = 1'b0;
    chk("frame_err_end", FW'(a_ferr), FW'(n - 1 == eb));
    if (eb >= 0) begin
      e8 = (e8 < 255) ? e8 + 1 : e8;
      e2 = (e2 < 3) ? e2 + 1 : e2;
    end
    chk_counts();
    chk("valid_end", FW'(a_valid), FW'(n == P));
    chk("tready_end", FW'(a_tready), FW'(n != P));
    if (n == P) chk("vector", a_data, exp_vec);
    @(negedge clk);
    chk("frame_err_clr", FW'(a_ferr), FW'(0));
  endtask
  task automatic release_hold(input int waitc);
    for (int c = 0; c < waitc; c++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = {$urandom(), $urandom()};
      tlast  = 1'($urandom_range(0, 1));
      chk("hold_valid", FW'(a_valid), FW'(1));
      chk("hold_tready", FW'(a_tready), FW'(0));
      chk("hold_vector", a_data, exp_vec);
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    mready = 1'b1;
    chk("hold_vector_last", a_data, exp_vec);
    chk("hold_valid_last", FW'(a_valid), FW'(1));
    @(negedge clk);
    mready = 1'b0;
    chk("released_valid", FW'(a_valid), FW'(0));
    chk("released_idx", FW'(a_idx), FW'(0));
    chk("released_tready", FW'(a_tready), FW'(1));
    chk("released_ferr", FW'(a_ferr), FW'(0));
  endtask
  task automatic chk_reset_state();
    chk("rst_tready", FW'(a_tready), FW'(1));
    chk("rst_valid", FW'(a_valid), FW'(0));
    chk("rst_idx", FW'(a_idx), FW'(0));
    chk("rst_ferr", FW'(a_ferr), FW'(0));
    chk("rst_data", a_data, '0);
    chk_counts();
  endtask
  initial begin
    total = 0; bad = 0; e8 = 0; e2 = 0; exp_vec = '0;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; mready = 1'b0; tdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state();
    send_frame(P, 1'b1);
    release_hold(20);
    send_frame(5, 1'b0);
    send_frame(P, 1'b0);
    release_hold(2);
    send_frame(16, 1'b0);
    send_frame(P, 1'b0);
    release_hold(0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("mid_ferr", FW'(a_ferr), FW'(0));
      tdata = {$urandom(), $urandom()}; tvalid = 1'b1; tlast = 1'b0;
    end
    @(negedge clk);
    chk("mid_idx", FW'(a_idx), FW'(7));
    rst = 1'b1; tvalid = 1'b1; tlast = 1'b1; mready = 1'b1;
    @(negedge clk);
    rst = 1'b0; tvalid = 1'b0; tlast = 1'b0; mready = 1'b0;
    exp_vec = '0; e8 = 0; e2 = 0;
    chk_reset_state();
    send_frame(P, 1'b0);
    release_hold(1);
    for (int k = 0; k < 5; k++) send_frame(int'($urandom_range(1, P - 1)), 1'b0);
    chk("sat_count2", FW'(b_cnt), FW'(3));
    chk("count8_five", FW'(a_cnt), FW'(5));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_feature_assembler.md
AXIS_FEATURE_ASSEMBLER -- requirements
Module: axis_feature_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of one stream word.
REQ-002 SHALL have parameter PACKETS_NUM, default 13: number of words per feature frame.
REQ-003 SHALL have parameter ERR_CNT_WIDTH, default 8: width of the frame-error counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all logic on posedge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 s_axis_tdata  input  DATA_WIDTH  stream word from the upstream AXIS slave stage.
REQ-008 s_axis_tvalid  input  1  upstream word valid.
REQ-009 s_axis_tready  output  1  this block accepts a word.
REQ-010 s_axis_tlast  input  1  last word of frame.
REQ-011 m_feat_data  output  DATA_WIDTH*PACKETS_NUM  assembled feature vector.
REQ-012 m_feat_valid  output  1  feature vector complete and stable.
REQ-013 m_feat_ready  input  1  inference core consumes the vector.
REQ-014 frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-015 err_count  output  ERR_CNT_WIDTH  saturating count of malformed frames.
REQ-016 word_idx  output  $clog2(PACKETS_NUM)  index of the next word slot.

Function
REQ-017 SHALL implement states COLLECT, HOLD and DRAIN.
REQ-018 A beat SHALL occur on any cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-019 s_axis_tready SHALL be 1 in COLLECT and DRAIN, and 0 in HOLD.
REQ-020 In COLLECT, a beat SHALL write s_axis_tdata to m_feat_data[word_idx*DATA_WIDTH +: DATA_WIDTH] and increment word_idx.
REQ-021 In COLLECT, a beat with word_idx==PACKETS_NUM-1 and tlast=1 SHALL enter HOLD, with m_feat_valid=1 on the next cycle (1-cycle latency).
REQ-022 In COLLECT, a beat with word_idx<PACKETS_NUM-1 and tlast=1 (short frame) SHALL store the word, pulse frame_err, reset word_idx to 0, and stay in COLLECT.
REQ-023 In COLLECT, a beat with word_idx==PACKETS_NUM-1 and tlast=0 (long frame) SHALL pulse frame_err, reset word_idx to 0, and enter DRAIN.
REQ-024 DRAIN SHALL discard beats without writing them, and return to COLLECT after the beat that has tlast=1.
REQ-025 In HOLD, m_feat_data SHALL stay stable and m_feat_valid SHALL stay 1 until m_feat_ready=1.
REQ-026 When m_feat_ready=1 in HOLD, the block SHALL clear m_feat_valid, set word_idx to 0, and enter COLLECT; the first new beat SHALL be accepted no earlier than the following cycle.
REQ-027 m_feat_ready SHALL be ignored outside HOLD.
REQ-028 Each frame_err pulse SHALL increment err_count, which saturates at all-ones.
REQ-029 m_feat_data contents outside HOLD SHALL be treated as don't-care by consumers; slots not overwritten keep their old values.
REQ-030 frame_err SHALL be a registered output lasting exactly one cycle per error.

Reset
REQ-031 On rst=1, the block SHALL go to COLLECT with word_idx=0, m_feat_valid=0, frame_err=0, err_count=0 and m_feat_data=0.
REQ-032 rst SHALL take priority over every concurrent event, including a beat or m_feat_ready.
REQ-033 A reset in mid-frame or in HOLD SHALL drop the partial or pending vector without asserting frame_err.
REQ-034 s_axis_tready SHALL be 1 on the first cycle after reset is released.

Structure
REQ-035 A shared package SHALL hold the state enum typedef (COLLECT/HOLD/DRAIN) and the FEATURE_WIDTH localparam rule (DATA_WIDTH*PACKETS_NUM).
REQ-036 The saturating error counter SHALL be a sub-module named sat_counter, parameterised by width.

Verification
REQ-037 Good frame: 13 beats with data 0x1..0xD and tlast on beat 13 -> m_feat_valid=1 on the next cycle; slot k=k+1; s_axis_tready=0 until m_feat_ready.
REQ-038 Back-pressure: hold m_feat_ready=0 for 20 cycles with upstream tvalid=1 -> no beats accepted, m_feat_data unchanged; then 1-cycle ready -> COLLECT, word_idx=0.
REQ-039 Short frame: tlast on beat 5 -> frame_err for 1 cycle, err_count=1, no m_feat_valid; the next good frame assembles correctly.
REQ-040 Long frame: 16 beats with tlast on beat 16 -> frame_err on beat 13, beats 14-16 discarded, err_count=1; the next good frame is correct.
REQ-041 Saturation: with ERR_CNT_WIDTH=2, five short frames -> err_count=3.
REQ-042 Reset mid-frame: rst after beat 7, then a full good frame -> correct vector, frame_err never asserted, err_count=0.
